// File: rtl/exc_flush_redirect_if.sv
// Exception flush/redirect bundle: ec-stage commit inputs, the IF-side fetch
// handshake observations, and the redirect handshake towards the PC generator.
//   master : pipeline side, drives the commit/fetch/ready signals and sees the results
//   slave  : exc_flush_redirect, consumes commits and drives flush/stall/discard/redirect
//   exc_oc, ec_eret, cp0_epc[31:0]          ec-stage exception / eret commit and EPC
//   if_req_fire, if_resp_valid              fetch request handshake / response last beat
//   redirect_ready                          PC generator accepts redirect_pc
//   flush, fetch_stall, resp_discard        pipeline kill, IF issue hold, stale response drop
//   redirect_valid, redirect_pc[31:0], busy redirect handshake and activity flag
interface exc_flush_redirect_if;
    localparam int unsigned PC_W = 32;

    logic            exc_oc;
    logic            ec_eret;
    logic [PC_W-1:0] cp0_epc;
    logic            if_req_fire;
    logic            if_resp_valid;
    logic            redirect_ready;
    logic            flush;
    logic            fetch_stall;
    logic            resp_discard;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            busy;

    modport master (
        output exc_oc, ec_eret, cp0_epc, if_req_fire, if_resp_valid, redirect_ready,
        input  flush, fetch_stall, resp_discard, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_oc, ec_eret, cp0_epc, if_req_fire, if_resp_valid, redirect_ready,
        output flush, fetch_stall, resp_discard, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_flush_redirect.sv
// exc_flush_redirect: consumer of the ec-stage exception/eret commit. On an accepted
// event it pulses flush for one cycle, stalls fetch while the fetch responses that
// were in flight at the event are dropped, then offers the new PC (exception vector
// or EPC) to the PC generator over a valid/ready handshake.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   efr (slave modport)   commit inputs, fetch handshake, redirect handshake, status
//   stat_exc/stat_eret/stat_discard [31:0]  event/discard counters (EXC_FLUSH_STATS_EN only)
// Configuration macro: EXC_FLUSH_STATS_EN adds the statistics counters and ports.
// resp_discard is combinational off if_resp_valid so IF can drop a response in the
// cycle it returns; every other output is a flop.
module exc_flush_redirect #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned MAX_OUTS   = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    exc_flush_redirect_if.slave  efr
`ifdef EXC_FLUSH_STATS_EN
    ,
    output logic [31:0]          stat_exc,
    output logic [31:0]          stat_eret,
    output logic [31:0]          stat_discard
`endif
);
    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  outs_cnt;
    logic [CNT_W-1:0]  outs_nxt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  drop_nxt;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   target_nxt;
    logic              flush_nxt;
    logic              outs_inc;
    logic              outs_dec;
    logic              outs_ovf;
    logic              outs_unf;
    logic              discard_c;
    logic              event_c;

    assign event_c   = efr.exc_oc || efr.ec_eret;
    assign discard_c = (state == S_DRAIN) && efr.if_resp_valid && (drop_cnt != '0);
    assign efr.resp_discard = discard_c;

    // Outstanding fetch tracker; a simultaneous request and response cancel out.
    always_comb begin
        outs_inc = efr.if_req_fire && !efr.if_resp_valid;
        outs_dec = efr.if_resp_valid && !efr.if_req_fire;
        outs_ovf = outs_inc && (outs_cnt == CNT_W'(MAX_OUTS));
        outs_unf = outs_dec && (outs_cnt == '0);
        outs_nxt = outs_cnt;
        if (outs_inc && !outs_ovf) begin
            outs_nxt = outs_cnt + CNT_W'(1);
        end else if (outs_dec && !outs_unf) begin
            outs_nxt = outs_cnt - CNT_W'(1);
        end
    end

    // Next-state logic; drop_cnt snapshots outs_nxt so a request firing on the
    // event cycle is counted as stale too.
    always_comb begin
        state_nxt  = state;
        drop_nxt   = drop_cnt;
        target_nxt = target;
        flush_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (event_c) begin
                    target_nxt = efr.exc_oc ? EXC_VECTOR : efr.cp0_epc;
                    drop_nxt   = outs_nxt;
                    flush_nxt  = 1'b1;
                    state_nxt  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (discard_c) begin
                    drop_nxt = drop_cnt - CNT_W'(1);
                end
                if (drop_nxt == '0) begin
                    state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (efr.redirect_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, the latter decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            outs_cnt           <= '0;
            drop_cnt           <= '0;
            target             <= '0;
            efr.flush          <= 1'b0;
            efr.fetch_stall    <= 1'b0;
            efr.busy           <= 1'b0;
            efr.redirect_valid <= 1'b0;
            efr.redirect_pc    <= '0;
        end else begin
            state              <= state_nxt;
            outs_cnt           <= outs_nxt;
            drop_cnt           <= drop_nxt;
            target             <= target_nxt;
            efr.flush          <= flush_nxt;
            efr.fetch_stall    <= (state_nxt != S_IDLE);
            efr.busy           <= (state_nxt != S_IDLE);
            efr.redirect_valid <= (state_nxt == S_REDIRECT);
            efr.redirect_pc    <= (state_nxt == S_REDIRECT) ? target_nxt : '0;
        end
    end

`ifdef EXC_FLUSH_STATS_EN
    // Event and discard counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_exc     <= '0;
            stat_eret    <= '0;
            stat_discard <= '0;
        end else begin
            if (state == S_IDLE && efr.exc_oc) begin
                stat_exc <= stat_exc + 32'd1;
            end else if (state == S_IDLE && efr.ec_eret) begin
                stat_eret <= stat_eret + 32'd1;
            end
            if (discard_c) begin
                stat_discard <= stat_discard + 32'd1;
            end
        end
    end
`endif

    // Protocol checks; events while busy are legal but worth flagging.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!outs_ovf)
                else $error("exc_flush_redirect: fetch request beyond MAX_OUTS outstanding");
            assert (!outs_unf)
                else $error("exc_flush_redirect: fetch response with nothing outstanding");
            assert (!(state == S_DRAIN && efr.if_req_fire))
                else $error("exc_flush_redirect: fetch request issued while draining");
            assert (!(state != S_IDLE && event_c))
                else $warning("exc_flush_redirect: commit event while busy ignored");
        end
    end
endmodule

// File: tb/tb_exc_flush_redirect.sv
module tb_exc_flush_redirect;
    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic reset = 1'b1;

    exc_flush_redirect_if bus();

`ifdef EXC_FLUSH_STATS_EN
    logic [31:0] stat_exc;
    logic [31:0] stat_eret;
    logic [31:0] stat_discard;
`endif

    exc_flush_redirect dut (
        .clk   (clk),
        .reset (reset),
        .efr   (bus)
`ifdef EXC_FLUSH_STATS_EN
        ,
        .stat_exc     (stat_exc),
        .stat_eret    (stat_eret),
        .stat_discard (stat_discard)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exc_oc         = 1'b0;
        bus.ec_eret        = 1'b0;
        bus.cp0_epc        = 32'h0;
        bus.if_req_fire    = 1'b0;
        bus.if_resp_valid  = 1'b0;
        bus.redirect_ready = 1'b0;
    endtask

    task automatic issue_reqs(input int n);
        bus.if_req_fire = 1'b1;
        repeat (n) tick();
        bus.if_req_fire = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if ({bus.flush, bus.fetch_stall, bus.resp_discard, bus.redirect_valid, bus.busy} !== 5'b0
            || bus.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b pc=%h, expected 00000 / 00000000",
                {bus.flush, bus.fetch_stall, bus.resp_discard, bus.redirect_valid, bus.busy},
                bus.redirect_pc);
        end
        reset = 1'b0;
        tick();
    endtask

    // Exception with nothing outstanding and ready tied high: minimum turnaround.
    task automatic test_exc_basic();
        bus.redirect_ready = 1'b1;
        bus.exc_oc = 1'b1;
        sb_q.push_back(EXC_VEC);
        tick();
        bus.exc_oc = 1'b0;
        checks++;
        if ({bus.flush, bus.busy, bus.fetch_stall, bus.redirect_valid} !== 4'b1110) begin
            errors++;
            $display("FAIL exc_t1_flags: got %b expected 1110",
                {bus.flush, bus.busy, bus.fetch_stall, bus.redirect_valid});
        end
        tick();
        checks++;
        if ({bus.flush, bus.redirect_valid} !== 2'b01) begin
            errors++;
            $display("FAIL exc_t2_valid: flush/valid got %b expected 01",
                {bus.flush, bus.redirect_valid});
        end
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL exc_t2_pc: got %h expected %h", bus.redirect_pc, exp_pc);
        end
        tick();
        checks++;
        if ({bus.busy, bus.redirect_valid, bus.fetch_stall} !== 3'b000 || bus.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL exc_t3_idle: flags=%b pc=%h expected 000 / 00000000",
                {bus.busy, bus.redirect_valid, bus.fetch_stall}, bus.redirect_pc);
        end
    endtask

    // Eret with two responses in flight arriving at t2 and t5.
    task automatic test_eret_drain();
        bus.redirect_ready = 1'b1;
        issue_reqs(2);
        bus.ec_eret = 1'b1;
        bus.cp0_epc = 32'h8000_1234;
        sb_q.push_back(32'h8000_1234);
        tick();
        bus.ec_eret = 1'b0;
        bus.cp0_epc = 32'hDEAD_BEEF;
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL eret_flush: got %b expected 1", bus.flush);
        end
        tick();
        bus.if_resp_valid = 1'b1;
        #1;
        checks++;
        if (bus.resp_discard !== 1'b1) begin
            errors++;
            $display("FAIL eret_discard_t2: got %b expected 1", bus.resp_discard);
        end
        tick();
        bus.if_resp_valid = 1'b0;
        tick();
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.fetch_stall !== 1'b1) begin
            errors++;
            $display("FAIL eret_t4_draining: valid=%b stall=%b expected 0/1",
                bus.redirect_valid, bus.fetch_stall);
        end
        tick();
        bus.if_resp_valid = 1'b1;
        #1;
        checks++;
        if (bus.resp_discard !== 1'b1) begin
            errors++;
            $display("FAIL eret_discard_t5: got %b expected 1", bus.resp_discard);
        end
        tick();
        bus.if_resp_valid = 1'b0;
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL eret_t6_redirect: valid=%b pc=%h expected 1 / %h",
                bus.redirect_valid, bus.redirect_pc, exp_pc);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.redirect_ready = 1'b1;
        bus.exc_oc  = 1'b1;
        bus.ec_eret = 1'b1;
        bus.cp0_epc = 32'h0000_1234;
        sb_q.push_back(EXC_VEC);
        tick();
        idle_inputs();
        bus.redirect_ready = 1'b1;
        tick();
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL simul_priority: valid=%b pc=%h expected 1 / %h",
                bus.redirect_valid, bus.redirect_pc, exp_pc);
        end
        tick();
    endtask

    // Request firing on the event cycle is also stale; response in REDIRECT is kept.
    task automatic test_req_on_event();
        bus.redirect_ready = 1'b0;
        issue_reqs(1);
        bus.exc_oc = 1'b1;
        bus.if_req_fire = 1'b1;
        sb_q.push_back(EXC_VEC);
        tick();
        bus.exc_oc = 1'b0;
        bus.if_req_fire = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.if_resp_valid = 1'b1;
            #1;
            checks++;
            if (bus.resp_discard !== 1'b1) begin
                errors++;
                $display("FAIL reqev_discard_%0d: got %b expected 1", i, bus.resp_discard);
            end
            tick();
        end
        bus.if_resp_valid = 1'b0;
        checks++;
        if (bus.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL reqev_redirect_t3: got %b expected 1", bus.redirect_valid);
        end
        bus.if_req_fire = 1'b1;
        bus.if_resp_valid = 1'b1;
        #1;
        checks++;
        if (bus.resp_discard !== 1'b0) begin
            errors++;
            $display("FAIL reqev_keep_third: got %b expected 0", bus.resp_discard);
        end
        tick();
        bus.if_req_fire = 1'b0;
        bus.if_resp_valid = 1'b0;
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL reqev_pc: got %h expected %h", bus.redirect_pc, exp_pc);
        end
        bus.redirect_ready = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reqev_idle: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_ready_hold();
        bus.redirect_ready = 1'b0;
        bus.ec_eret = 1'b1;
        bus.cp0_epc = 32'hA5A5_0004;
        sb_q.push_back(32'hA5A5_0004);
        tick();
        bus.ec_eret = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== sb_q[0]) begin
                errors++;
                $display("FAIL hold_cycle_%0d: valid=%b pc=%h expected 1 / %h",
                    i, bus.redirect_valid, bus.redirect_pc, sb_q[0]);
            end
            bus.exc_oc = (i == 1);
            tick();
            bus.exc_oc = 1'b0;
        end
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL hold_final_pc: got %h expected %h", bus.redirect_pc, exp_pc);
        end
        bus.redirect_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored_exc: busy=%b flush=%b expected 0/0", bus.busy, bus.flush);
        end
    endtask

    // Fully loaded fetch bus: MAX_OUTS responses to drop.
    task automatic test_max_outs();
        bus.redirect_ready = 1'b1;
        issue_reqs(4);
        bus.exc_oc = 1'b1;
        sb_q.push_back(EXC_VEC);
        tick();
        bus.exc_oc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.if_resp_valid = 1'b1;
            #1;
            checks++;
            if (bus.resp_discard !== 1'b1 || bus.redirect_valid !== 1'b0) begin
                errors++;
                $display("FAIL max_discard_%0d: discard=%b valid=%b expected 1/0",
                    i, bus.resp_discard, bus.redirect_valid);
            end
            tick();
        end
        bus.if_resp_valid = 1'b0;
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL max_redirect: valid=%b pc=%h expected 1 / %h",
                bus.redirect_valid, bus.redirect_pc, exp_pc);
        end
        tick();
    endtask

    // A new event on the very cycle the block returns to IDLE.
    task automatic test_back_to_back();
        bus.redirect_ready = 1'b1;
        bus.exc_oc = 1'b1;
        sb_q.push_back(EXC_VEC);
        tick();
        bus.exc_oc = 1'b0;
        tick();
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL b2b_first_pc: got %h expected %h", bus.redirect_pc, exp_pc);
        end
        tick();
        bus.ec_eret = 1'b1;
        bus.cp0_epc = 32'h8000_0180;
        sb_q.push_back(32'h8000_0180);
        tick();
        bus.ec_eret = 1'b0;
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_flush: got %b expected 1", bus.flush);
        end
        tick();
        exp_pc = sb_q.pop_front();
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL b2b_second_pc: valid=%b pc=%h expected 1 / %h",
                bus.redirect_valid, bus.redirect_pc, exp_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.redirect_ready = 1'b1;
        issue_reqs(2);
        bus.ec_eret = 1'b1;
        bus.cp0_epc = 32'h1111_2220;
        tick();
        bus.ec_eret = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.flush, bus.fetch_stall, bus.resp_discard, bus.redirect_valid, bus.busy} !== 5'b0
            || bus.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b pc=%h expected 00000 / 00000000",
                {bus.flush, bus.fetch_stall, bus.resp_discard, bus.redirect_valid, bus.busy},
                bus.redirect_pc);
        end
        bus.if_resp_valid = 1'b1;
        repeat (2) tick();
        bus.if_resp_valid = 1'b0;
        reset = 1'b0;
        tick();
        bus.if_req_fire = 1'b1;
        bus.if_resp_valid = 1'b1;
        #1;
        checks++;
        if (bus.resp_discard !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_discard: discard=%b busy=%b expected 0/0",
                bus.resp_discard, bus.busy);
        end
        tick();
        bus.if_req_fire = 1'b0;
        bus.if_resp_valid = 1'b0;
`ifdef EXC_FLUSH_STATS_EN
        checks++;
        if (stat_exc !== 32'h0 || stat_eret !== 32'h0 || stat_discard !== 32'h0) begin
            errors++;
            $display("FAIL midreset_stats: exc=%0d eret=%0d discard=%0d expected 0/0/0",
                stat_exc, stat_eret, stat_discard);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_exc_basic();
        test_eret_drain();
        test_simultaneous();
        test_req_on_event();
        test_ready_hold();
        test_max_outs();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
